// File: rtl/noc_router_arb_pkg.sv
// ============================================================================
// Module      : noc_router_arb_pkg
// Description : Shared types and the round-robin selector for the NoC router
//               output arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package noc_router_arb_pkg;

    // Widest input vector the selector handles; arbiters use INPUTS <= this.
    localparam int unsigned c_MAX_INPUTS = 32;
    localparam int unsigned c_IDX_W      = $clog2(c_MAX_INPUTS);

    // Arbiter state: free to arbitrate, or holding one input for a worm.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // One-hot grant of the first set bit of valid at or above ptr, wrapping
    // at n. Returns zero when no bit in [0, n) is set.
    function automatic logic [c_MAX_INPUTS-1:0] rr_select(
        input logic [c_MAX_INPUTS-1:0] valid,
        input int unsigned             n,
        input int unsigned             ptr
    );
        logic [c_MAX_INPUTS-1:0] grant;
        logic                    found;
        int unsigned             idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < c_MAX_INPUTS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx[c_IDX_W-1:0]]) begin
                    grant[idx[c_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_router_output_slice.sv
// ============================================================================
// Module      : noc_router_output_slice
// Description : Registered output stage of the router output arbiter.
//               Exports o_accept: the stage can take a flit this cycle.
//               Build option NOC_ROUTER_ARB_SKID_EN selects a 2-entry skid
//               buffer (no combinational i_ready -> o_accept path); otherwise
//               a single pipeline register is used.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_router_output_slice #(
    parameter int FLIT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    input  logic                  i_last,
    output logic                  o_accept,
    output logic                  o_valid,
    output logic [FLIT_WIDTH-1:0] o_flit,
    output logic                  o_last,
    input  logic                  i_ready
);

    logic                  r_valid;
    logic                  r_last;
    logic [FLIT_WIDTH-1:0] r_flit;

    assign o_valid = r_valid;
    assign o_flit  = r_flit;
    assign o_last  = r_last;

`ifdef NOC_ROUTER_ARB_SKID_EN
    logic                  r_skid_valid;
    logic                  r_skid_last;
    logic [FLIT_WIDTH-1:0] r_skid_flit;

    // Accept is purely registered: only a full skid entry blocks upstream.
    assign o_accept = !r_skid_valid;

    // Main register refills from the skid entry first to keep ordering; a
    // flit arriving while the main register stalls parks in the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_flit       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_flit  <= '0;
        end else if (!r_valid || i_ready) begin
            if (r_skid_valid) begin
                r_valid      <= 1'b1;
                r_flit       <= r_skid_flit;
                r_last       <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else begin
                r_valid <= i_valid;
                if (i_valid) begin
                    r_flit <= i_flit;
                    r_last <= i_last;
                end
            end
        end else if (i_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_flit  <= i_flit;
            r_skid_last  <= i_last;
        end
    end
`else
    // Register is free when empty or draining this cycle.
    assign o_accept = !r_valid || i_ready;

    // Single pipeline register; holds its flit while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_flit  <= '0;
        end else if (o_accept) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_flit <= i_flit;
                r_last <= i_last;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/noc_router_output_arbiter.sv
// ============================================================================
// Module      : noc_router_output_arbiter
// Description : Round-robin arbiter for one router output port. Holds the
//               grant for a whole wormhole packet and drives one registered
//               output link. Optional skid stage via NOC_ROUTER_ARB_SKID_EN
//               (evaluated inside noc_router_output_slice). INPUTS <= 32.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_router_output_arbiter #(
    parameter int FLIT_WIDTH = 32,
    parameter int INPUTS     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    import noc_router_arb_pkg::*;

    localparam int c_PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_PTR_W-1:0]      w_ptr_nxt;
    logic [c_PTR_W-1:0]      r_lock_idx;
    logic [c_PTR_W-1:0]      w_lock_nxt;
    logic [c_PTR_W-1:0]      w_gidx;
    logic [INPUTS-1:0]       w_grant;
    logic [c_MAX_INPUTS-1:0] w_valid_ext;
    logic [c_MAX_INPUTS-1:0] w_rr_full;
    logic                    w_unused_rr;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_sel_last;
    logic [FLIT_WIDTH-1:0]   w_sel_flit;

    // Widen the valid vector to the selector's fixed width.
    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[INPUTS-1:0]  = in_valid;
    end

    assign w_rr_full   = rr_select(w_valid_ext, INPUTS, 32'(r_ptr));
    assign w_unused_rr = ^w_rr_full;

    // Locked: only the worm owner may send; idle: round-robin pick.
    always_comb begin
        w_grant = '0;
        if (r_state == ST_LOCKED) begin
            w_grant[r_lock_idx] = 1'b1;
        end else begin
            w_grant = w_rr_full[INPUTS-1:0];
        end
    end

    // Encode the one-hot grant into an index for muxing and pointer update.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_grant[i]) begin
                w_gidx = c_PTR_W'(i);
            end
        end
    end

    assign in_ready   = rst ? '0 : (w_grant & {INPUTS{w_accept}});
    assign w_xfer     = |(in_valid & in_ready);
    assign w_sel_flit = in_flit[w_gidx*FLIT_WIDTH +: FLIT_WIDTH];
    assign w_sel_last = in_last[w_gidx];

    // Next state: lock on a non-last head, release on the last flit;
    // pointer advances past the winner only when a packet starts.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = (w_gidx == c_PTR_W'(INPUTS - 1)) ? '0 : w_gidx + 1'b1;
                    if (!w_sel_last) begin
                        w_state_nxt = ST_LOCKED;
                        w_lock_nxt  = w_gidx;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_idx <= w_lock_nxt;
        end
    end

    noc_router_output_slice #(
        .FLIT_WIDTH (FLIT_WIDTH)
    ) u_slice (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (w_xfer),
        .i_flit   (w_sel_flit),
        .i_last   (w_sel_last),
        .o_accept (w_accept),
        .o_valid  (out_valid),
        .o_flit   (out_flit),
        .o_last   (out_last),
        .i_ready  (out_ready)
    );

endmodule

`default_nettype wire
